// File: rtl/decode_regfile_stage.sv
// rtl/decode_regfile_stage.sv - decode/operand-fetch stage: register file, hazard scoreboard, registered output
module decode_regfile_stage #(
    parameter int DATAW        = 32,
    parameter int NUMREGISTERS = 8,
    parameter int REGW         = $clog2(NUMREGISTERS),
    parameter int CTRLW        = 16,
    parameter int IMMW         = 11,
    parameter int BYPASS       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REGW-1:0]  in_rs1,
    input  logic [REGW-1:0]  in_rs2,
    input  logic [REGW-1:0]  in_rd,
    input  logic             in_rd_wr,
    input  logic [CTRLW-1:0] in_ctrl,
    input  logic [IMMW-1:0]  in_imm,
    input  logic             wb_en,
    input  logic [REGW-1:0]  wb_reg,
    input  logic [DATAW-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_a,
    output logic [DATAW-1:0] out_b,
    output logic [REGW-1:0]  out_rd,
    output logic             out_rd_wr,
    output logic [CTRLW-1:0] out_ctrl,
    output logic [IMMW-1:0]  out_imm
);

    localparam logic BYP = (BYPASS != 0);

    logic [DATAW-1:0]        rf_q [NUMREGISTERS];
    logic [DATAW-1:0]        rf_d [NUMREGISTERS];
    logic [NUMREGISTERS-1:0] pending_q, pending_d;
    logic [NUMREGISTERS-1:0] clr_now;

    logic             out_valid_q, out_valid_d;
    logic [DATAW-1:0] out_a_q, out_a_d;
    logic [DATAW-1:0] out_b_q, out_b_d;
    logic [REGW-1:0]  out_rd_q, out_rd_d;
    logic             out_rd_wr_q, out_rd_wr_d;
    logic [CTRLW-1:0] out_ctrl_q, out_ctrl_d;
    logic [IMMW-1:0]  out_imm_q, out_imm_d;

    logic             hazard;
    logic             accept;
    logic [DATAW-1:0] rs1_val, rs2_val;

    // A register whose write-back lands this cycle is only usable now if its data can be forwarded.
    always_comb begin
        clr_now = '0;
        for (int r = 0; r < NUMREGISTERS; r++) begin
            clr_now[r] = BYP && wb_en && (wb_reg == REGW'(r));
        end
    end

    always_comb begin
        hazard   = (pending_q[in_rs1] && !clr_now[in_rs1])
                || (pending_q[in_rs2] && !clr_now[in_rs2])
                || (in_rd_wr && pending_q[in_rd] && !clr_now[in_rd]);
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
        rs1_val  = (BYP && wb_en && (wb_reg == in_rs1)) ? wb_data : rf_q[in_rs1];
        rs2_val  = (BYP && wb_en && (wb_reg == in_rs2)) ? wb_data : rf_q[in_rs2];
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_reg] = wb_data;
        end
    end

    // Ordering matters: a new claim at accept overrides a same-cycle write-back clear.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_reg] = 1'b0;
        end
        if (flush && out_valid_q && out_rd_wr_q) begin
            pending_d[out_rd_q] = 1'b0;
        end
        if (accept && in_rd_wr) begin
            pending_d[in_rd] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;
        out_rd_wr_d = out_rd_wr_q;
        out_ctrl_d  = out_ctrl_q;
        out_imm_d   = out_imm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = rs1_val;
            out_b_d     = rs2_val;
            out_rd_d    = in_rd;
            out_rd_wr_d = in_rd_wr;
            out_ctrl_d  = in_ctrl;
            out_imm_d   = in_imm;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUMREGISTERS; r++) begin
                rf_q[r] <= '0;
            end
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_rd_wr_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_imm_q   <= '0;
        end else begin
            rf_q        <= rf_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
            out_rd_wr_q <= out_rd_wr_d;
            out_ctrl_q  <= out_ctrl_d;
            out_imm_q   <= out_imm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_rd_wr = out_rd_wr_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_imm   = out_imm_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// tb/tb_decode_regfile_stage.sv - scoreboard bench for decode_regfile_stage (forwarding and non-forwarding instances)
module tb_decode_regfile_stage;

    localparam int DW = 32;
    localparam int NR = 8;
    localparam int RW = 3;
    localparam int CW = 16;
    localparam int IW = 11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_rd_wr, wb_en, flush, out_valid, out_ready, out_rd_wr;
    logic [RW-1:0] in_rs1, in_rs2, in_rd, wb_reg, out_rd;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [IW-1:0] in_imm, out_imm;
    logic [DW-1:0] wb_data, out_a, out_b;

    logic          n_in_valid, n_in_ready, n_in_rd_wr, n_wb_en, n_flush, n_out_valid, n_out_ready, n_out_rd_wr;
    logic [RW-1:0] n_in_rs1, n_in_rs2, n_in_rd, n_wb_reg, n_out_rd;
    logic [CW-1:0] n_in_ctrl, n_out_ctrl;
    logic [IW-1:0] n_in_imm, n_out_imm;
    logic [DW-1:0] n_wb_data, n_out_a, n_out_b;

    decode_regfile_stage #(.DATAW(DW), .NUMREGISTERS(NR), .CTRLW(CW), .IMMW(IW), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
        .in_ctrl(in_ctrl), .in_imm(in_imm), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_rd_wr(out_rd_wr), .out_ctrl(out_ctrl), .out_imm(out_imm)
    );

    decode_regfile_stage #(.DATAW(DW), .NUMREGISTERS(NR), .CTRLW(CW), .IMMW(IW), .BYPASS(0)) ndut (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_rs1(n_in_rs1), .in_rs2(n_in_rs2), .in_rd(n_in_rd), .in_rd_wr(n_in_rd_wr),
        .in_ctrl(n_in_ctrl), .in_imm(n_in_imm), .wb_en(n_wb_en), .wb_reg(n_wb_reg), .wb_data(n_wb_data),
        .flush(n_flush), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_a(n_out_a), .out_b(n_out_b),
        .out_rd(n_out_rd), .out_rd_wr(n_out_rd_wr), .out_ctrl(n_out_ctrl), .out_imm(n_out_imm)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RW-1:0] rd;
        logic          rd_wr;
        logic [CW-1:0] ctrl;
        logic [IW-1:0] imm;
    } exp_t;

    exp_t sbq[$];

    // Reference state: architectural registers, outstanding writers, output-stage occupancy.
    logic [DW-1:0] mrf [NR];
    bit            mpend [NR];
    bit            m_ov;
    logic [RW-1:0] m_rd;
    bit            m_rd_wr;
    bit            mon_en = 1'b0;

    function automatic bit busy(input logic [RW-1:0] r);
        return mpend[r] && !(wb_en && wb_reg == r);
    endfunction

    function automatic bit model_ready();
        bit hz;
        hz = busy(in_rs1) || busy(in_rs2) || (in_rd_wr && busy(in_rd));
        return (!m_ov || out_ready) && !hz && !flush;
    endfunction

    task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit rdwr,
                        input bit wbe, input int wbr, input logic [DW-1:0] wbd, input bit fl, input bit ordy);
        bit   rdy;
        bit   acc;
        exp_t e;
        in_valid  = v;
        in_rs1    = RW'(rs1);
        in_rs2    = RW'(rs2);
        in_rd     = RW'(rd);
        in_rd_wr  = rdwr;
        in_ctrl   = CW'($urandom);
        in_imm    = IW'($urandom);
        wb_en     = wbe;
        wb_reg    = RW'(wbr);
        wb_data   = wbd;
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        rdy = model_ready();
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        @(posedge clk);
        acc = in_valid && rdy;
        if (acc) begin
            e.a     = (wb_en && wb_reg == in_rs1) ? wb_data : mrf[in_rs1];
            e.b     = (wb_en && wb_reg == in_rs2) ? wb_data : mrf[in_rs2];
            e.rd    = in_rd;
            e.rd_wr = in_rd_wr;
            e.ctrl  = in_ctrl;
            e.imm   = in_imm;
            sbq.push_back(e);
        end
        if (wb_en) mpend[wb_reg] = 1'b0;
        if (flush && m_ov && m_rd_wr) mpend[m_rd] = 1'b0;
        if (acc && in_rd_wr) mpend[in_rd] = 1'b1;
        if (flush) m_ov = 1'b0;
        else if (acc) begin
            m_ov    = 1'b1;
            m_rd    = in_rd;
            m_rd_wr = in_rd_wr;
        end else if (out_ready) m_ov = 1'b0;
        if (wb_en) mrf[wb_reg] = wb_data;
        #1;
    endtask

    task automatic nset(input bit v, input int rs1, input int rd, input bit rdwr,
                        input bit wbe, input int wbr, input logic [DW-1:0] wbd);
        n_in_valid = v;
        n_in_rs1   = RW'(rs1);
        n_in_rs2   = '0;
        n_in_rd    = RW'(rd);
        n_in_rd_wr = rdwr;
        n_wb_en    = wbe;
        n_wb_reg   = RW'(wbr);
        n_wb_data  = wbd;
    endtask

    // Monitor: compares the presented output against the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("out_valid_extra", {63'd0, out_valid}, 64'd0);
                end else begin
                    chk("out_a", {32'd0, out_a}, {32'd0, sbq[0].a});
                    chk("out_b", {32'd0, out_b}, {32'd0, sbq[0].b});
                    chk("out_meta", {33'd0, out_rd, out_rd_wr, out_ctrl, out_imm},
                        {33'd0, sbq[0].rd, sbq[0].rd_wr, sbq[0].ctrl, sbq[0].imm});
                    if (out_ready || flush) void'(sbq.pop_front());
                end
            end else begin
                chk("out_valid", {63'd0, out_valid}, {63'd0, sbq.size() != 0});
            end
        end
    end

    initial begin
        for (int r = 0; r < NR; r++) begin
            mrf[r]   = '0;
            mpend[r] = 1'b0;
        end
        m_ov = 1'b0; m_rd = '0; m_rd_wr = 1'b0;
        rst_n = 1'b0;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wr = 0; in_ctrl = 0; in_imm = 0;
        wb_en = 0; wb_reg = 0; wb_data = 0; flush = 0; out_ready = 1;
        nset(0, 0, 0, 0, 0, 0, 0);
        n_in_ctrl = 0; n_in_imm = 0; n_flush = 0; n_out_ready = 1;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ops", {out_a, out_b}, 64'd0);
        chk("rst_out_meta", {33'd0, out_rd, out_rd_wr, out_ctrl, out_imm}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_n_in_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        step(0, 0, 0, 0, 0, 1, 3, 32'h0000_00AA, 0, 1);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 5, 1, 0, 0, 1, 5, 32'h0000_1234, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, i, 3, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 2, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 2, 2, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 4, 1, 1, 4, 32'h0000_0044, 0, 1);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 4, 1, 1, 4, 32'h0000_0055, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Non-forwarding instance: the consumer waits one extra cycle after write-back.
        nset(1, 0, 5, 1, 0, 0, 0);
        @(negedge clk); chk("nb_producer_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1;
        nset(1, 5, 0, 0, 0, 0, 0);
        @(negedge clk); chk("nb_stall_ready", {63'd0, n_in_ready}, 64'd0);
        @(posedge clk); #1;
        nset(1, 5, 0, 0, 1, 5, 32'h0000_1234);
        @(negedge clk); chk("nb_wb_cycle_ready", {63'd0, n_in_ready}, 64'd0);
        @(posedge clk); #1;
        nset(1, 5, 0, 0, 0, 0, 0);
        @(negedge clk); chk("nb_after_wb_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1;
        nset(1, 0, 5, 1, 0, 0, 0);
        @(negedge clk);
        chk("nb_out_valid", {63'd0, n_out_valid}, 64'd1);
        chk("nb_out_a", {32'd0, n_out_a}, 64'h1234);
        chk("nb_out_b", {32'd0, n_out_b}, 64'd0);
        chk("nb_pending_cleared", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk); #1;
        nset(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) step(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        mon_en = 1'b0;
        in_valid = 0; flush = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("async_rst_n_out_valid", {63'd0, n_out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
